// File: rtl/ray_stepper_stream_if.sv
// Ray/box request and exit-result channel between the ray generator and ray_stepper_stream.
// The iters field exists only when RAY_STEPPER_ITERS_EN is defined.
interface ray_stepper_stream_if #(
    parameter int WIDTH = 16
`ifdef RAY_STEPPER_ITERS_EN
    , parameter int ITER_W = $clog2(WIDTH + 3)
`endif
);
    logic                  inValid;
    logic                  inReady;
    logic [2:0][WIDTH-1:0] q;
    logic [2:0][WIDTH-1:0] v;
    logic [2:0][WIDTH-1:0] l;
    logic [2:0][WIDTH-1:0] u;
    logic                  abort;
    logic                  outValid;
    logic                  outReady;
    logic [2:0][WIDTH-1:0] qp;
    logic [1:0]            status;
    logic [2:0]            exitAxis;
`ifdef RAY_STEPPER_ITERS_EN
    logic [ITER_W-1:0]     iters;
`endif

    modport master (
        output inValid, q, v, l, u, abort, outReady,
        input  inReady, outValid, qp, status, exitAxis
`ifdef RAY_STEPPER_ITERS_EN
        , input iters
`endif
    );

    modport slave (
        input  inValid, q, v, l, u, abort, outReady,
        output inReady, outValid, qp, status, exitAxis
`ifdef RAY_STEPPER_ITERS_EN
        , output iters
`endif
    );
endinterface

// File: rtl/ray_stepper_stream.sv
// Streaming ray/AABB exit search: halving-step binary search for the first position just outside the box.
// Define RAY_STEPPER_ITERS_EN to expose the iteration count on the iters port.
module ray_stepper_stream #(
    parameter int WIDTH     = 16,
    parameter int MAX_ITERS = WIDTH + 2,
    parameter int ITER_W    = $clog2(MAX_ITERS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    ray_stepper_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP, HOLD} state_t;

    localparam logic [1:0]              ST_EXIT    = 2'd0;
    localparam logic [1:0]              ST_OOB     = 2'd1;
    localparam logic [1:0]              ST_TIMEOUT = 2'd2;
    localparam logic signed [WIDTH+1:0] P_ONE      = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH:0]   R_ONE      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]       CNT_ONE    = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]       LAST_CNT   = ITER_W'(MAX_ITERS);

    state_t                state_q, state_d;
    logic [2:0][WIDTH-1:0] acc_q, acc_d;
    logic [2:0][WIDTH-1:0] l_q, l_d;
    logic [2:0][WIDTH-1:0] u_q, u_d;
    logic signed [WIDTH:0] step_q [3];
    logic signed [WIDTH:0] step_d [3];
    logic [ITER_W-1:0]     cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            status_q, status_d;
    logic [2:0]            exit_axis_q, exit_axis_d;
`ifdef RAY_STEPPER_ITERS_EN
    logic [ITER_W-1:0]     iters_q, iters_d;
`endif

    logic signed [WIDTH:0]   r [3];
    logic signed [WIDTH+1:0] p [3];
    logic [2:0]              in_v, on_v, oob_v;
    logic                    all_in, any_on, any_oob, accept;
    logic [ITER_W-1:0]       cnt_inc;

    // Odd non-negative steps round up so a positive search can still land exactly on u+1.
    always_comb begin
        logic signed [WIDTH+1:0] lo, hi;
        in_v  = '0;
        on_v  = '0;
        oob_v = '0;
        for (int i = 0; i < 3; i++) begin
            r[i] = step_q[i] >>> 1;
            if (!step_q[i][WIDTH] && step_q[i][0]) begin
                r[i] = r[i] + R_ONE;
            end
            p[i]     = $signed({2'b00, acc_q[i]}) + $signed({r[i][WIDTH], r[i]});
            lo       = $signed({2'b00, l_q[i]}) - P_ONE;
            hi       = $signed({2'b00, u_q[i]}) + P_ONE;
            in_v[i]  = (p[i] >= lo) && (p[i] <= hi);
            on_v[i]  = (p[i] == lo) || (p[i] == hi);
            oob_v[i] = (p[i][WIDTH+1:WIDTH] != 2'b00);
        end
    end

    assign all_in  = &in_v;
    assign any_on  = |on_v;
    assign any_oob = |oob_v;
    assign cnt_inc = cnt_q + CNT_ONE;
    assign accept  = bus.inValid && bus.inReady;

    // abort outranks both finishing and accepting; HOLD can hand straight over to a new ray.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        l_d         = l_q;
        u_d         = u_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        status_d    = status_q;
        exit_axis_d = exit_axis_q;
`ifdef RAY_STEPPER_ITERS_EN
        iters_d     = iters_q;
`endif
        if (bus.abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                STEP: begin
                    for (int i = 0; i < 3; i++) begin
                        step_d[i] = step_q[i] >>> 1;
                        if (all_in) begin
                            acc_d[i] = p[i][WIDTH-1:0];
                        end
                    end
                    cnt_d = cnt_inc;
                    if (all_in && any_on) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        status_d    = any_oob ? ST_OOB : ST_EXIT;
                        exit_axis_d = on_v;
`ifdef RAY_STEPPER_ITERS_EN
                        iters_d     = cnt_inc;
`endif
                    end else if (cnt_inc == LAST_CNT) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        status_d    = ST_TIMEOUT;
                        exit_axis_d = 3'b000;
`ifdef RAY_STEPPER_ITERS_EN
                        iters_d     = cnt_inc;
`endif
                    end
                end
                HOLD: begin
                    if (bus.outReady) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                state_d     = STEP;
                out_valid_d = 1'b0;
                acc_d       = bus.q;
                l_d         = bus.l;
                u_d         = bus.u;
                cnt_d       = '0;
                for (int i = 0; i < 3; i++) begin
                    step_d[i] = {bus.v[i], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            l_q         <= '0;
            u_q         <= '0;
            step_q      <= '{default: '0};
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            status_q    <= ST_EXIT;
            exit_axis_q <= 3'b000;
`ifdef RAY_STEPPER_ITERS_EN
            iters_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            l_q         <= l_d;
            u_q         <= u_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            status_q    <= status_d;
            exit_axis_q <= exit_axis_d;
`ifdef RAY_STEPPER_ITERS_EN
            iters_q     <= iters_d;
`endif
        end
    end

    assign bus.inReady  = !bus.abort && ((state_q == IDLE) || ((state_q == HOLD) && bus.outReady));
    assign bus.outValid = out_valid_q;
    assign bus.qp       = acc_q;
    assign bus.status   = status_q;
    assign bus.exitAxis = exit_axis_q;
`ifdef RAY_STEPPER_ITERS_EN
    assign bus.iters    = iters_q;
`endif
endmodule

// File: tb/tb_ray_stepper_stream.sv
// Scoreboard bench for ray_stepper_stream: hand-derived expected exits queued at accept, checked at the result handshake.
module tb_ray_stepper_stream;
    typedef logic [2:0][15:0] coord_t;
    typedef struct {
        coord_t     qp;
        logic [1:0] status;
        logic [2:0] axis;
        int         iters;
        int         accept_cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t pending;
    logic prev_valid = 1'b0;

    ray_stepper_stream_if #(.WIDTH(16)) bus ();

    ray_stepper_stream #(.WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    function automatic coord_t vec3(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        return {z, y, x};
    endfunction

    function automatic exp_t mk_exp(input coord_t qp, input logic [1:0] st, input logic [2:0] ax, input int it);
        exp_t e;
        e.qp         = qp;
        e.status     = st;
        e.axis       = ax;
        e.iters      = it;
        e.accept_cyc = 0;
        return e;
    endfunction

    // Results are compared at the handshake; latency counts edges from the accepting edge to outValid rising.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset || bus.abort) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.outValid && !prev_valid) begin
                if (sb.size() == 0) checkOutput("unexpected_valid", 64'(bus.outValid), 64'd0);
                else checkOutput("latency", 64'(cyc - sb[0].accept_cyc), 64'(sb[0].iters + 1));
            end
            if (bus.outValid && bus.outReady && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("qp", 64'(bus.qp), 64'(e.qp));
                checkOutput("status", 64'(bus.status), 64'(e.status));
                checkOutput("exitAxis", 64'(bus.exitAxis), 64'(e.axis));
`ifdef RAY_STEPPER_ITERS_EN
                checkOutput("iters", 64'(bus.iters), 64'(e.iters));
`endif
            end
            if (bus.inValid && bus.inReady) begin
                e = pending;
                e.accept_cyc = cyc;
                sb.push_back(e);
            end
            prev_valid = bus.outValid;
        end
    end

    task automatic sync_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input coord_t qi, input coord_t vi, input coord_t li, input coord_t ui,
                                 input exp_t e, output int waited);
        pending     = e;
        bus.q       = qi;
        bus.v       = vi;
        bus.l       = li;
        bus.u       = ui;
        bus.inValid = 1'b1;
        waited      = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (bus.inReady) begin
                waited = k;
                break;
            end
        end
        if (waited < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic wait_drain();
        logic done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain", 64'(done), 64'd1);
    endtask

    task automatic run_case(input coord_t qi, input coord_t vi, input coord_t li, input coord_t ui, input exp_t e);
        int waited;
        sync_drive();
        applyStimulus(qi, vi, li, ui, e, waited);
        wait_drain();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        coord_t lo0, hi1k, hiMax, q500, v1;
        exp_t   e1, e2;
        coord_t snap_qp;
        logic [1:0] snap_st;
        logic [2:0] snap_ax;
        logic stable, ready_seen, seen_valid;
        int waited;

        bus.inValid  = 1'b0;
        bus.q        = '0;
        bus.v        = '0;
        bus.l        = '0;
        bus.u        = '0;
        bus.abort    = 1'b0;
        bus.outReady = 1'b1;

        lo0   = vec3(16'd0, 16'd0, 16'd0);
        hi1k  = vec3(16'd1000, 16'd1000, 16'd1000);
        hiMax = vec3(16'hFFFF, 16'hFFFF, 16'hFFFF);
        q500  = vec3(16'd500, 16'd500, 16'd500);
        v1    = vec3(16'd1024, 16'd0, 16'd0);
        e1    = mk_exp(vec3(16'd1001, 16'd500, 16'd500), 2'd0, 3'b001, 11);
        e2    = mk_exp(vec3(16'h0000, 16'd5, 16'd5), 2'd1, 3'b001, 5);

        #12;
        checkOutput("rst_outValid", 64'(bus.outValid), 64'd0);
        checkOutput("rst_status", 64'(bus.status), 64'd0);
        checkOutput("rst_exitAxis", 64'(bus.exitAxis), 64'd0);
        checkOutput("rst_qp", 64'(bus.qp), 64'd0);
        checkOutput("rst_inReady", 64'(bus.inReady), 64'd1);
`ifdef RAY_STEPPER_ITERS_EN
        checkOutput("rst_iters", 64'(bus.iters), 64'd0);
`endif
        #10;
        reset = 1'b1;

        run_case(q500, v1, lo0, hi1k, e1);
        run_case(vec3(16'hFFF0, 16'd5, 16'd5), vec3(16'h0100, 16'd0, 16'd0), lo0, hiMax, e2);
        run_case(vec3(16'd10, 16'd10, 16'd10), vec3(16'd0, 16'd0, 16'd0), lo0, vec3(16'd100, 16'd100, 16'd100),
                 mk_exp(vec3(16'd10, 16'd10, 16'd10), 2'd2, 3'b000, 18));
        run_case(vec3(16'd150, 16'd500, 16'd500), vec3(16'hFFC0, 16'd0, 16'd0), vec3(16'd100, 16'd0, 16'd0),
                 vec3(16'd200, 16'd1000, 16'd1000), mk_exp(vec3(16'd99, 16'd500, 16'd500), 2'd0, 3'b001, 7));
        run_case(q500, vec3(16'd1024, 16'd1024, 16'd0), lo0, hi1k,
                 mk_exp(vec3(16'd1001, 16'd1001, 16'd500), 2'd0, 3'b011, 11));

        // Stall the consumer, then release it together with a queued ray.
        sync_drive();
        bus.outReady = 1'b0;
        applyStimulus(q500, v1, lo0, hi1k, e1, waited);
        seen_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (bus.outValid) begin
                seen_valid = 1'b1;
                break;
            end
        end
        checkOutput("hold_valid", 64'(seen_valid), 64'd1);
        snap_qp    = bus.qp;
        snap_st    = bus.status;
        snap_ax    = bus.exitAxis;
        stable     = 1'b1;
        ready_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!bus.outValid || bus.qp !== snap_qp || bus.status !== snap_st || bus.exitAxis !== snap_ax)
                stable = 1'b0;
            if (bus.inReady) ready_seen = 1'b1;
        end
        checkOutput("hold_stable", 64'(stable), 64'd1);
        checkOutput("hold_inReady", 64'(ready_seen), 64'd0);
        sync_drive();
        bus.outReady = 1'b1;
        applyStimulus(vec3(16'hFFF0, 16'd5, 16'd5), vec3(16'h0100, 16'd0, 16'd0), lo0, hiMax, e2, waited);
        checkOutput("b2b_wait", 64'(waited), 64'd0);
        wait_drain();

        // Abort a few iterations in, then re-issue the same ray.
        sync_drive();
        applyStimulus(q500, v1, lo0, hi1k, e1, waited);
        repeat (2) @(posedge clock);
        #1;
        bus.abort = 1'b1;
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        @(negedge clock);
        checkOutput("abort_idle", 64'(bus.inReady), 64'd1);
        seen_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (bus.outValid) seen_valid = 1'b1;
        end
        checkOutput("abort_no_valid", 64'(seen_valid), 64'd0);
        run_case(q500, v1, lo0, hi1k, e1);

        // Asynchronous reset mid-search.
        sync_drive();
        applyStimulus(q500, v1, lo0, hi1k, e1, waited);
        repeat (4) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_outValid", 64'(bus.outValid), 64'd0);
        checkOutput("areset_qp", 64'(bus.qp), 64'd0);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("areset_inReady", 64'(bus.inReady), 64'd1);
        run_case(vec3(16'hFFF0, 16'd5, 16'd5), vec3(16'h0100, 16'd0, 16'd0), lo0, hiMax, e2);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
